// File: rtl/pc_redirect.sv
// pc_redirect: fetch-side PC sequencer.
// Produces the fetch address and applies EX-stage taken-branch redirects.
// Each redirect holds a multi-cycle flush of the younger stages.
// A redirect whose target equals its own EX pc parks the core in HALT until resume.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_BOOT  | first cycle out of reset, fetch not yet live
// S_RUN   | sequential fetch, stall holds pc, taken branch redirects
// S_FLUSH | younger stages being flushed, fcnt counts down to exit
// S_HALT  | parked on a self-targeted branch, waits for resume
module pc_redirect #(
  parameter int unsigned       ADDR_W       = 48,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_stall,
  input  logic              iw_branch_taken,
  input  logic [ADDR_W-1:0] iw_branch_pc,
  input  logic [ADDR_W-1:0] iw_ex_pc,
  input  logic              iw_resume,
  output logic [ADDR_W-1:0] ow_pc,
  output logic              ow_fetch_valid,
  output logic              ow_flush,
  output logic              ow_halted,
  output logic [15:0]       ow_redirect_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALT} state_e;

  // Loaded on a redirect so that the counter reaches zero on the last flush cycle.
  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fv_q, fv_d;
  logic              flush_q, flush_d;
  logic              halted_q, halted_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              halt_pend_q, halt_pend_d;
  logic              self_target;

  assign self_target = (iw_branch_pc == iw_ex_pc);

  // State and datapath registers; reset takes effect immediately.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      fv_q        <= 1'b0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= 16'd0;
      fcnt_q      <= 3'd0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fv_q        <= fv_d;
      flush_q     <= flush_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next state, next pc, flush countdown and redirect count.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (iw_branch_taken) begin
          state_d     = S_FLUSH;
          pc_d        = iw_branch_pc;
          fcnt_d      = FCNT_LOAD;
          halt_pend_d = self_target;
          if (!self_target && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
        end else if (!iw_stall) begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      S_FLUSH: begin
        if (fcnt_q == 3'd0) begin
          state_d     = halt_pend_q ? S_HALT : S_RUN;
          halt_pend_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      S_HALT: begin
        if (iw_resume) begin
          state_d = S_RUN;
          pc_d    = pc_q + ADDR_W'(1);
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Registered status outputs follow directly from the state being entered.
  always_comb begin
    fv_d     = (state_d == S_RUN);
    flush_d  = (state_d == S_FLUSH);
    halted_d = (state_d == S_HALT);
  end

  assign ow_pc           = pc_q;
  assign ow_fetch_valid  = fv_q;
  assign ow_flush        = flush_q;
  assign ow_halted       = halted_q;
  assign ow_redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect.sv
// tb_pc_redirect: directed bench for pc_redirect with a cycle-level reference model.
// u0 (RESET_PC=1000, FLUSH_CYCLES=2) is checked every cycle against the model.
// u1 (FLUSH_CYCLES=1, fast clock) is driven into redirect-counter saturation.
`timescale 1ns/1ps
module tb_pc_redirect;

  localparam int AW = 48;
  localparam logic [AW-1:0] RPC = 48'h1000;
  localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0, clk_f = 1'b0;
  always #5 clk = ~clk;
  always #1 clk_f = ~clk_f;

  logic          rst = 1'b1, stall = 1'b0, taken = 1'b0, resume = 1'b0;
  logic [AW-1:0] bpc = '0, expc = '0;
  logic [AW-1:0] pc;
  logic          fv, flush, halted;
  logic [15:0]   cnt;

  logic          s_rst = 1'b1, s_taken = 1'b0;
  logic [AW-1:0] s_bpc = 48'h5, s_expc = 48'h0;
  logic [AW-1:0] s_pc;
  logic          s_fv, s_flush, s_halted;
  logic [15:0]   s_cnt;

  pc_redirect #(.ADDR_W(AW), .RESET_PC(RPC), .FLUSH_CYCLES(2)) u0 (
    .iw_clk(clk), .iw_rst(rst), .iw_stall(stall), .iw_branch_taken(taken),
    .iw_branch_pc(bpc), .iw_ex_pc(expc), .iw_resume(resume),
    .ow_pc(pc), .ow_fetch_valid(fv), .ow_flush(flush), .ow_halted(halted),
    .ow_redirect_cnt(cnt));

  pc_redirect #(.ADDR_W(AW), .RESET_PC(48'h0), .FLUSH_CYCLES(1)) u1 (
    .iw_clk(clk_f), .iw_rst(s_rst), .iw_stall(1'b0), .iw_branch_taken(s_taken),
    .iw_branch_pc(s_bpc), .iw_ex_pc(s_expc), .iw_resume(1'b0),
    .ow_pc(s_pc), .ow_fetch_valid(s_fv), .ow_flush(s_flush), .ow_halted(s_halted),
    .ow_redirect_cnt(s_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for u0: mode, remaining flush cycles, pending park.
  int            m_mode = M_BOOT;
  int            m_left = 0;
  bit            m_park = 1'b0;
  logic [AW-1:0] m_pc = RPC;
  logic          m_fv = 1'b0, m_flush = 1'b0, m_halted = 1'b0;
  int            m_cnt = 0;

  // Model update on each clock edge, reset applied asynchronously.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_BOOT; m_left = 0; m_park = 1'b0; m_pc = RPC;
      m_fv = 1'b0; m_flush = 1'b0; m_halted = 1'b0; m_cnt = 0;
    end else begin
      case (m_mode)
        M_BOOT: begin m_mode = M_RUN; m_fv = 1'b1; end
        M_RUN: begin
          if (taken) begin
            m_pc = bpc; m_fv = 1'b0; m_flush = 1'b1;
            m_left = 2; m_park = (bpc == expc); m_mode = M_FLUSH;
            if (!m_park && m_cnt < 65535) m_cnt++;
          end else if (!stall) begin
            m_pc = m_pc + 1;
          end
        end
        M_FLUSH: begin
          m_left--;
          if (m_left == 0) begin
            m_flush = 1'b0;
            if (m_park) begin m_mode = M_HALT; m_halted = 1'b1; end
            else begin m_mode = M_RUN; m_fv = 1'b1; end
          end
        end
        default: begin
          if (resume) begin
            m_pc = m_pc + 1; m_halted = 1'b0; m_fv = 1'b1; m_mode = M_RUN;
          end
        end
      endcase
    end
  end

  bit cmp_en = 1'b0;

  // Compare u0 against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_pc", pc, m_pc);
      chk("cyc_fetch_valid", fv, m_fv);
      chk("cyc_flush", flush, m_flush);
      chk("cyc_halted", halted, m_halted);
      chk("cyc_redirect_cnt", cnt, 16'(m_cnt));
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, RPC);
    chk({tag, "_fv"}, fv, 1'b0);
    chk({tag, "_flush"}, flush, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_cnt"}, cnt, 16'd0);
  endtask

  task automatic main_flow();
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    // boot and sequential fetch
    @(negedge clk); chk("boot_pc", pc, 48'h1000); chk("boot_fv", fv, 1'b1);
    @(negedge clk); chk("seq_pc1", pc, 48'h1001);
    @(negedge clk); chk("seq_pc2", pc, 48'h1002); chk("seq_flush", flush, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_br_pc", pc, 48'h1005);
    // plain redirect
    taken = 1'b1; bpc = 48'h3000; expc = 48'h1003;
    @(negedge clk); taken = 1'b0;
    chk("br_pc", pc, 48'h3000); chk("br_flush1", flush, 1'b1); chk("br_fv", fv, 1'b0);
    @(negedge clk); chk("br_flush2", flush, 1'b1);
    @(negedge clk); chk("br_done_fv", fv, 1'b1); chk("br_done_flush", flush, 1'b0);
    chk("br_tgt_pc", pc, 48'h3000); chk("br_cnt", cnt, 16'd1);
    @(negedge clk); chk("br_next_pc", pc, 48'h3001);
    // stall, then taken while stalled, stall held through flush
    stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_pc", pc, 48'h3001);
    taken = 1'b1; bpc = 48'h0123_4567_89AB; expc = 48'h3001;
    @(negedge clk); taken = 1'b0;
    chk("stbr_pc", pc, 48'h0123_4567_89AB); chk("stbr_flush", flush, 1'b1);
    @(negedge clk);
    @(negedge clk); chk("stbr_end_flush", flush, 1'b0); chk("stbr_end_fv", fv, 1'b1);
    chk("stbr_cnt", cnt, 16'd2);
    stall = 1'b0;
    @(negedge clk);
    // self-targeted branch parks the core
    taken = 1'b1; bpc = 48'h0100; expc = 48'h0100;
    @(negedge clk); taken = 1'b0; chk("hlt_flush", flush, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("hlt_halted", halted, 1'b1); chk("hlt_pc", pc, 48'h0100);
    chk("hlt_fv", fv, 1'b0); chk("hlt_cnt", cnt, 16'd2);
    taken = 1'b1; stall = 1'b1; bpc = 48'h5555; expc = 48'h0;
    repeat (2) @(negedge clk);
    chk("hlt_ign_pc", pc, 48'h0100); chk("hlt_ign_halted", halted, 1'b1);
    taken = 1'b0; stall = 1'b0; resume = 1'b1;
    @(negedge clk);
    chk("res_pc", pc, 48'h0101); chk("res_halted", halted, 1'b0); chk("res_fv", fv, 1'b1);
    @(negedge clk); resume = 1'b0;
    chk("res_run_pc", pc, 48'h0102);
    // wrap at all-ones
    taken = 1'b1; bpc = 48'hFFFF_FFFF_FFFF; expc = 48'h0;
    @(negedge clk); taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_top", pc, 48'hFFFF_FFFF_FFFF);
    @(negedge clk); chk("wrap_zero", pc, 48'h0); chk("wrap_cnt", cnt, 16'd3);
    // reset in the middle of a flush
    taken = 1'b1; bpc = 48'h0200; expc = 48'h0;
    @(posedge clk); #3; taken = 1'b0;
    chk("mf_flush", flush, 1'b1);
    rst = 1'b1; #1;
    chk_reset("mf_rst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); chk("mf_boot_fv", fv, 1'b1);
    // reset while halted
    taken = 1'b1; bpc = 48'h0300; expc = 48'h0300;
    @(negedge clk); taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("mh_halted", halted, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk_reset("mh_rst");
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic sat_flow();
    repeat (3) @(negedge clk_f);
    chk("s_rst_pc", s_pc, 48'h0); chk("s_rst_cnt", s_cnt, 16'd0);
    s_rst = 1'b0; s_taken = 1'b1;
    @(negedge clk_f); chk("s_boot_fv", s_fv, 1'b1); chk("s_boot_pc", s_pc, 48'h0);
    @(negedge clk_f);
    chk("s_br_flush", s_flush, 1'b1); chk("s_br_pc", s_pc, 48'h5); chk("s_br_cnt", s_cnt, 16'd1);
    @(negedge clk_f);
    chk("s_f1_flush", s_flush, 1'b0); chk("s_f1_fv", s_fv, 1'b1);
    repeat (131068 - 3) @(posedge clk_f);
    @(negedge clk_f); chk("s_cnt_fffe", s_cnt, 16'hFFFE);
    repeat (2) @(posedge clk_f);
    @(negedge clk_f); chk("s_cnt_ffff", s_cnt, 16'hFFFF);
    repeat (6) @(posedge clk_f);
    @(negedge clk_f); chk("s_cnt_sat", s_cnt, 16'hFFFF); chk("s_halted", s_halted, 1'b0);
    s_taken = 1'b0;
  endtask

  initial begin
    fork
      main_flow();
      sat_flow();
    join
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect.md
Name: pc_redirect

Overview:
Fetch-side PC sequencer; the consumer end of the EX-stage branch interface (ow_branch_taken / ow_branch_pc from stg_ex).
- Generates the fetch address.
- Applies taken-branch redirects.
- Drives a multi-cycle flush of the younger pipeline stages.
- Parks the core in a halt state on a self-targeted redirect, the SRHLT convention where branch_pc equals the EX pc.
- Sits between the hazard unit / stg_ex and the IF stage.

Parameters:
- ADDR_W, 48, PC width (matches `HBIT_ADDR+1).
- RESET_PC, 48'h0, fetch address after reset.
- FLUSH_CYCLES, 2, number of cycles ow_flush is held per redirect; legal range 1..7.

Ports:
- iw_clk  in  1  clock, all state updates on rising edge.
- iw_rst  in  1  reset; asynchronous, active-high.
- iw_stall  in  1  hazard-unit stall; holds PC in RUN.
- iw_branch_taken  in  1  EX redirect request.
- iw_branch_pc  in  ADDR_W  EX redirect target.
- iw_ex_pc  in  ADDR_W  PC of the instruction in EX; used for halt detection.
- iw_resume  in  1  wake request (debug/interrupt); only acted on in HALT.
- ow_pc  out  ADDR_W  fetch address (registered).
- ow_fetch_valid  out  1  fetch at ow_pc is live (registered).
- ow_flush  out  1  flush IF..ID younger stages (registered).
- ow_halted  out  1  core parked (registered).
- ow_redirect_cnt  out  16  count of non-halt redirects, saturating (registered).

Behaviour:
- States: BOOT, RUN, FLUSH, HALT. A 3-bit flush counter fcnt and a 1-bit halt_pend flag.
- Reset values (asynchronous):
  - state=BOOT, ow_pc=RESET_PC, ow_fetch_valid=0, ow_flush=0, ow_halted=0.
  - ow_redirect_cnt=0, fcnt=0, halt_pend=0.
  - Asserting reset mid-FLUSH or mid-HALT returns everything to these values immediately.
- BOOT: at the first edge after reset release, go to RUN with ow_fetch_valid=1 and ow_pc=RESET_PC (no increment).
- RUN, evaluated at each edge. Priority: taken > stall > advance.
  - iw_branch_taken=1 and iw_branch_pc!=iw_ex_pc (redirect):
    - ow_pc<=iw_branch_pc, ow_fetch_valid<=0, ow_flush<=1, fcnt<=FLUSH_CYCLES-1, halt_pend<=0, go to FLUSH.
    - ow_redirect_cnt<=cnt+1, saturating at 16'hFFFF.
  - iw_branch_taken=1 and iw_branch_pc==iw_ex_pc (halt):
    - Same as a redirect, but halt_pend<=1 and ow_redirect_cnt is unchanged.
  - Taken wins over iw_stall when both are high.
  - iw_stall=1, no taken: hold ow_pc; ow_fetch_valid stays 1.
  - Otherwise: ow_pc<=ow_pc+1, wrapping modulo 2^ADDR_W (all-ones -> 0).
- FLUSH:
  - ow_flush=1 and ow_fetch_valid=0 throughout; ow_pc holds the target.
  - fcnt decrements every edge; iw_stall does not pause it.
  - iw_branch_taken is ignored, since EX holds only flushed bubbles.
  - At the edge where fcnt==0:
    - ow_flush<=0.
    - halt_pend=0: go to RUN with ow_fetch_valid<=1.
    - halt_pend=1: go to HALT with ow_halted<=1 and ow_fetch_valid staying 0.
  - Net effect: ow_flush is high for exactly FLUSH_CYCLES cycles, and the first valid fetch of the target is FLUSH_CYCLES cycles after the redirect edge.
- HALT:
  - ow_pc holds the halting instruction's PC; ow_fetch_valid=0, ow_flush=0, ow_halted=1.
  - iw_stall and iw_branch_taken are ignored.
  - iw_resume=1 at an edge: ow_pc<=ow_pc+1 (wrapping), ow_halted<=0, ow_fetch_valid<=1, go to RUN. No flush is needed because the pipeline is already empty.
- iw_resume outside HALT has no effect.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset with RESET_PC=48'h1000, release, no stall for 4 cycles -> ow_pc sequence 1000,1000(BOOT->RUN),1001,1002; ow_fetch_valid 0 then 1; ow_flush=0.
2. In RUN at pc 1005, pulse iw_branch_taken with branch_pc=48'h3000 and ex_pc=48'h1003 -> next cycle ow_pc=3000, ow_flush=1 for exactly 2 cycles, ow_fetch_valid=0 for those 2 cycles, then 1 with pc 3000 then 3001; ow_redirect_cnt=1.
3. Assert iw_stall in RUN for 3 cycles -> ow_pc frozen. Assert taken (target 48'h012345_6789AB) with stall still high -> redirect still taken. Hold stall during FLUSH -> the flush still ends after 2 cycles.
4. Taken with branch_pc=ex_pc=48'h0100 -> flush for 2 cycles, then ow_halted=1, ow_pc=0100, ow_fetch_valid=0, ow_redirect_cnt unchanged. Apply taken and stall while halted -> no change. Pulse iw_resume -> ow_pc=0101, ow_halted=0, ow_fetch_valid=1.
5. Redirect to 48'hFFFF_FFFF_FFFF, let it run -> ow_pc wraps to 0. Force 65536 redirects -> ow_redirect_cnt stays 16'hFFFF.
6. Assert iw_rst mid-FLUSH and mid-HALT -> all outputs return to reset values immediately, without waiting for a clock edge.
